// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and data ports, data-first with fetch fairness and timeout
module mem_port_arbiter #(
  parameter int FAIR_MAX = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_load,
  input  logic        d_store,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);
  localparam int FW = $clog2(FAIR_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
  state_t state, state_nx;
  logic owner, err, d_pend, f_win, timeout, rd_cap;
  logic [FW-1:0] fair_cnt;
  logic [TW-1:0] wait_cnt;
  assign d_pend = d_load | d_store;
  assign f_win = if_req & (~d_pend | (fair_cnt == FW'(FAIR_MAX)));
  assign timeout = wait_cnt == TW'(TIMEOUT - 1);
  assign rd_cap = (state == GRANT) & mem_ack & ~mem_we;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = (state == IDLE) ? ((if_req | d_pend) ? GRANT : IDLE)
             : (state == GRANT) ? ((mem_ack | timeout) ? RESP : GRANT) : IDLE;
    mem_req = state == GRANT;
    if_ready = (state == RESP) & ~owner;
    d_ready = (state == RESP) & owner;
    bus_err = (state == RESP) & err;
  end
  always_ff @(posedge clk)
    if (reset) begin
      owner <= 1'b0;
      err <= 1'b0;
      fair_cnt <= '0;
      wait_cnt <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (state == IDLE) begin
        fair_cnt <= (!if_req || f_win) ? '0 : fair_cnt + FW'(1);
        if (if_req | d_pend) begin
          owner <= ~f_win;
          mem_addr <= f_win ? if_addr : d_addr;
          mem_we <= ~f_win & d_store;
          mem_wdata <= (~f_win & d_store) ? d_wdata : '0;
          wait_cnt <= '0;
        end
      end
      if (state == GRANT) begin
        wait_cnt <= wait_cnt + TW'(1);
        err <= ~mem_ack & timeout;
      end
      if (rd_cap & owner) d_rdata <= mem_rdata;
      if (rd_cap & ~owner) if_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int FAIR_MAX = 4;
  localparam int TIMEOUT = 16;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          dly;
  } grant_t;
  logic clk = 0, reset = 1;
  logic if_req = 0, d_load = 0, d_store = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_ready, d_ready, mem_req, mem_we, bus_err;
  int checks = 0, errors = 0;
  int ack_dly = 0;
  bit rand_dly = 0, noise = 0;
  logic [31:0] exp_if = 0, exp_d = 0;
  logic [31:0] mem [logic [31:0]];
  grant_t grants[$];
  int dly_tab [11] = '{0, 0, 0, 1, 1, 2, 3, 5, 15, 16, -1};
  always #5 clk = ~clk;
  mem_port_arbiter #(.FAIR_MAX(FAIR_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_load(d_load), .d_store(d_store), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );
  function automatic logic [31:0] mval(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  initial begin : mem_model
    int w, d;
    w = 0;
    d = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 0;
      mem_rdata = $urandom;
      if (mem_req === 1'b1) begin
        if (w == 0) begin
          d = rand_dly ? dly_tab[$urandom_range(0, 10)] : ack_dly;
          grants.push_back('{mem_addr, mem_we, mem_wdata, d});
        end
        if (w == d) begin
          mem_ack = 1;
          mem_rdata = mval(mem_addr);
          if (mem_we) mem[mem_addr] = mem_wdata;
        end
        w++;
      end else begin
        w = 0;
        mem_ack = noise && ($urandom_range(0, 1) == 1);
      end
    end
  end
  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 0 || if_ready !== 0 || d_ready !== 0 || bus_err !== 0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b ir=%b dr=%b err=%b want all 0", mem_req, if_ready, d_ready, bus_err);
    end
    checks++;
    if (if_rdata !== 0 || d_rdata !== 0) begin
      errors++;
      $display("FAIL reset_rdata got if=%h d=%h want 0", if_rdata, d_rdata);
    end
    checks++;
    if (mem_addr !== 0 || mem_wdata !== 0 || mem_we !== 0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h wd=%h we=%b want 0", mem_addr, mem_wdata, mem_we);
    end
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  task automatic test_fetch();
    mem[32'h40] = 32'h2008_0005;
    ack_dly = 0;
    @(posedge clk);
    #1;
    if_req = 1;
    if_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (mem_req !== 0) begin
      errors++;
      $display("FAIL fetch_idle got req=%b want 0", mem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h40 || mem_we !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL fetch_grant got req=%b addr=%h we=%b wd=%h want 1/00000040/0/0", mem_req, mem_addr, mem_we, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (if_ready !== 1 || d_ready !== 0 || bus_err !== 0 || if_rdata !== 32'h2008_0005 || mem_req !== 0) begin
      errors++;
      $display("FAIL fetch_resp got ir=%b dr=%b err=%b rd=%h req=%b want 1/0/0/20080005/0", if_ready, d_ready, bus_err, if_rdata, mem_req);
    end
    exp_if = 32'h2008_0005;
    @(posedge clk);
    #1;
    if_req = 0;
    @(negedge clk);
    checks++;
    if (if_ready !== 0) begin
      errors++;
      $display("FAIL fetch_pulse got ir=%b want 0", if_ready);
    end
  endtask
  task automatic test_simul();
    int n;
    grants.delete();
    mem[32'h100] = 32'h1111_0100;
    mem[32'h44] = 32'h2222_0044;
    ack_dly = 1;
    @(posedge clk);
    #1;
    d_load = 1;
    d_addr = 32'h100;
    if_req = 1;
    if_addr = 32'h44;
    n = 0;
    while (d_ready !== 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 4 || bus_err !== 0 || d_rdata !== 32'h1111_0100 || if_rdata !== exp_if) begin
      errors++;
      $display("FAIL simul_data got lat=%0d err=%b d=%h if=%h want 4/0/11110100/%h", n, bus_err, d_rdata, if_rdata, exp_if);
    end
    exp_d = 32'h1111_0100;
    @(posedge clk);
    #1;
    d_load = 0;
    n = 0;
    while (if_ready !== 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 4 || bus_err !== 0 || if_rdata !== 32'h2222_0044 || d_rdata !== exp_d) begin
      errors++;
      $display("FAIL simul_fetch got lat=%0d err=%b if=%h d=%h want 4/0/22220044/%h", n, bus_err, if_rdata, d_rdata, exp_d);
    end
    exp_if = 32'h2222_0044;
    @(posedge clk);
    #1;
    if_req = 0;
    checks++;
    if (grants.size() != 2 || grants[0].addr !== 32'h100 || grants[1].addr !== 32'h44) begin
      errors++;
      $display("FAIL simul_order got n=%0d want grants 00000100 then 00000044", grants.size());
    end
  endtask
  task automatic test_starve();
    int n, nwe;
    logic [9:0] seq;
    ack_dly = 0;
    grants.delete();
    seq = '0;
    @(posedge clk);
    #1;
    d_store = 1;
    d_addr = 32'h180;
    d_wdata = $urandom;
    if_req = 1;
    if_addr = 32'h48;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (if_ready !== 1 && d_ready !== 1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      seq[i] = if_ready;
      @(posedge clk);
      #1;
      d_wdata = $urandom;
      if (seq[i]) if_addr = if_addr + 4;
    end
    d_store = 0;
    if_req = 0;
    checks++;
    if (seq !== 10'b10_0001_0000) begin
      errors++;
      $display("FAIL starve_order got %b want 1000010000 (bit i = fetch won i-th grant)", seq);
    end
    nwe = 0;
    foreach (grants[i]) nwe += grants[i].we;
    checks++;
    if (grants.size() != 10 || nwe != 8 || d_rdata !== exp_d) begin
      errors++;
      $display("FAIL starve_stores got grants=%0d writes=%0d d=%h want 10/8/%h", grants.size(), nwe, d_rdata, exp_d);
    end
  endtask
  task automatic test_timeout();
    int n, hi;
    int dl [3] = '{-1, 15, 16};
    logic e_err;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      ack_dly = dl[i];
      a = 32'h200 + 32'(4 * i);
      mem[a] = 32'h7777_0000 | a;
      e_err = dl[i] < 0 || dl[i] >= TIMEOUT;
      @(posedge clk);
      #1;
      d_load = 1;
      d_addr = a;
      n = 0;
      hi = 0;
      while (d_ready !== 1 && n < 60) begin
        @(negedge clk);
        n++;
        hi += int'(mem_req);
      end
      if (!e_err) exp_d = mval(a);
      checks++;
      if (hi != TIMEOUT || d_ready !== 1 || bus_err !== e_err || d_rdata !== exp_d || if_ready !== 0) begin
        errors++;
        $display("FAIL timeout_dly%0d got req_cycles=%0d dr=%b err=%b d=%h want %0d/1/%b/%h", dl[i], hi, d_ready, bus_err, d_rdata, TIMEOUT, e_err, exp_d);
      end
      @(posedge clk);
      #1;
      d_load = 0;
    end
  endtask
  task automatic test_store_prio();
    ack_dly = 0;
    @(posedge clk);
    #1;
    d_load = 1;
    d_store = 1;
    d_addr = 32'h300;
    d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1 || mem_we !== 1 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL store_bus got req=%b we=%b wd=%h addr=%h want 1/1/cafef00d/00000300", mem_req, mem_we, mem_wdata, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (d_ready !== 1 || bus_err !== 0 || d_rdata !== exp_d) begin
      errors++;
      $display("FAIL store_resp got dr=%b err=%b d=%h want 1/0/%h", d_ready, bus_err, d_rdata, exp_d);
    end
    @(posedge clk);
    #1;
    d_load = 0;
    d_store = 0;
  endtask
  task automatic test_reset_grant();
    int n;
    ack_dly = -1;
    @(posedge clk);
    #1;
    if_req = 1;
    if_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1) begin
      errors++;
      $display("FAIL rstg_grant got req=%b want 1", mem_req);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if (mem_req !== 0 || if_ready !== 0 || if_rdata !== 0 || d_rdata !== 0) begin
      errors++;
      $display("FAIL rstg_abort got req=%b ir=%b if=%h d=%h want 0/0/0/0", mem_req, if_ready, if_rdata, d_rdata);
    end
    @(posedge clk);
    #1;
    reset = 0;
    if_req = 0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_ready !== 0 || d_ready !== 0 || mem_req !== 0) n++;
    end
    checks++;
    if (n != 0 || if_rdata !== 0 || d_rdata !== 0) begin
      errors++;
      $display("FAIL rstg_quiet got active_cycles=%0d if=%h d=%h want 0/0/0", n, if_rdata, d_rdata);
    end
    exp_if = 0;
    exp_d = 0;
  endtask
  task automatic test_random();
    int txns, idle, fgap, dgap, streak, op;
    logic p_if, p_dl, p_ds, pr_req, cur_f, cur_err, cur_we, f_done, d_done, exp_f;
    logic [31:0] p_ia, p_da, p_dw, cur_addr, cur_rd, e_wd;
    grant_t g;
    rand_dly = 1;
    noise = 1;
    grants.delete();
    txns = 0;
    idle = 0;
    fgap = 1;
    dgap = 0;
    streak = 0;
    {p_if, p_dl, p_ds, pr_req, cur_f, cur_err, cur_we, f_done, d_done} = '0;
    {p_ia, p_da, p_dw, cur_addr, cur_rd} = '0;
    while (txns < 150 && idle < 60) begin
      @(negedge clk);
      idle++;
      if (mem_req === 1'b1 && !pr_req) begin
        exp_f = p_if && (!(p_dl || p_ds) || streak == FAIR_MAX);
        streak = (!p_if || exp_f) ? 0 : streak + 1;
        cur_f = exp_f;
        cur_we = !exp_f && p_ds;
        cur_addr = exp_f ? p_ia : p_da;
        e_wd = cur_we ? p_dw : 32'h0;
        cur_rd = mval(cur_addr);
        checks++;
        if (grants.size() == 0) begin
          errors++;
          $display("FAIL rnd_grant got no logged grant want one at addr %h", cur_addr);
        end else begin
          g = grants.pop_front();
          cur_err = g.dly < 0 || g.dly >= TIMEOUT;
          if (g.addr !== cur_addr || g.we !== cur_we || g.wdata !== e_wd) begin
            errors++;
            $display("FAIL rnd_grant got addr=%h we=%b wd=%h want %h/%b/%h", g.addr, g.we, g.wdata, cur_addr, cur_we, e_wd);
          end
        end
      end
      if (mem_req === 1'b1) begin
        checks++;
        if (mem_addr !== cur_addr || mem_we !== cur_we) begin
          errors++;
          $display("FAIL rnd_hold got addr=%h we=%b want %h/%b", mem_addr, mem_we, cur_addr, cur_we);
        end
      end
      if (if_ready === 1'b1 || d_ready === 1'b1) begin
        idle = 0;
        txns++;
        checks++;
        if (if_ready !== cur_f || d_ready !== !cur_f || bus_err !== cur_err) begin
          errors++;
          $display("FAIL rnd_resp got ir=%b dr=%b err=%b want %b/%b/%b", if_ready, d_ready, bus_err, cur_f, !cur_f, cur_err);
        end
        if (!cur_err && !cur_we) begin
          if (cur_f) exp_if = cur_rd;
          else exp_d = cur_rd;
        end
        checks++;
        if (if_rdata !== exp_if || d_rdata !== exp_d) begin
          errors++;
          $display("FAIL rnd_rdata got if=%h d=%h want %h/%h", if_rdata, d_rdata, exp_if, exp_d);
        end
        if (if_ready === 1'b1) f_done = 1;
        if (d_ready === 1'b1) d_done = 1;
      end
      pr_req = mem_req === 1'b1;
      @(posedge clk);
      #1;
      {p_if, p_dl, p_ds, p_ia, p_da, p_dw} = {if_req, d_load, d_store, if_addr, d_addr, d_wdata};
      if (f_done) begin
        f_done = 0;
        if_req = 0;
        fgap = $urandom_range(0, 3);
      end
      if (!if_req) begin
        if (fgap == 0) begin
          if_req = 1;
          if_addr = 32'h1000 + 32'(4 * $urandom_range(0, 63));
        end else fgap--;
      end
      if (d_done) begin
        d_done = 0;
        d_load = 0;
        d_store = 0;
        dgap = $urandom_range(0, 2);
      end
      if (!(d_load || d_store)) begin
        if (dgap == 0) begin
          op = $urandom_range(0, 2);
          d_load = op != 1;
          d_store = op != 0;
          d_addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 7));
          d_wdata = $urandom;
        end else dgap--;
      end
    end
    checks++;
    if (txns < 150) begin
      errors++;
      $display("FAIL rnd_progress got %0d completions want 150", txns);
    end
    noise = 0;
    rand_dly = 0;
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_simul();
    test_starve();
    test_timeout();
    test_store_prio();
    test_reset_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule
